zero_flag_pipe: RTL and testbench
=================================

Name: zero_flag_pipe

Overview:
- Parametrised, pipelined successor to the 32-bit combinational zero detector.
- Reduces a WIDTH-bit ALU result through a registered FAN-input OR/AND tree and produces zero, all-ones and negative flags.
- Uses a valid/ready handshake with full-pipeline stall.
- Sits between the ALU result and the branch/flag logic; an optional saturating counter records zero-result events.

Parameters:
WIDTH, 32, result width in bits (>=1)
FAN, 4, inputs per reduction node per level (>=2)
CNT_W, 16, width of zero-event counter

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  data is valid this cycle
in_ready  output  1  block accepts data this cycle
data  input  WIDTH  ALU result to test
out_valid  output  1  flags valid
out_ready  input  1  consumer accepts flags
zero  output  1  1 when the accepted data was all zeros
ones  output  1  1 when the accepted data was all ones
neg  output  1  data[WIDTH-1] of the accepted data
cnt_clr  input  1  synchronous clear of zero_cnt
zero_cnt  output  CNT_W  count of zero results delivered

Behaviour:
- Levels:
  - LEVELS = max(1, ceil(log_FAN(WIDTH))), a derived localparam.
  - WIDTH=32, FAN=4 gives 32->8->2->1, LEVELS=3.
- Reduction tree:
  - Each level holds an OR tree (for zero) and an AND tree (for ones).
  - Each level is registered, with one valid bit per level.
  - MSB is carried alongside the trees.
  - Partial groups: pad the OR tree with 0 and the AND tree with 1.
  - zero = NOT(final OR); ones = final AND.
- Latency: exactly LEVELS cycles from the accept edge (in_valid && in_ready) to out_valid, when out_ready stays high.
- Stall and handshake:
  - advance = out_ready || !out_valid.
  - in_ready = advance; this path is combinational from out_ready, which is intentional.
  - When advance=1, every stage shifts one level. Stage-0 valid loads in_valid; the last stage drives out_valid/zero/ones/neg.
  - When advance=0, all stage registers hold, including valids and flags.
  - Bubbles are not collapsed.
  - Data not accepted (in_valid=0) enters as a bubble; its flag bits are don't-care but must not toggle the outputs while out_valid=0.
  - Outputs are stable while out_valid=1 and out_ready=0.
- Throughput: one result per cycle when out_ready is held high.
- Reset:
  - Asynchronous. Clears all stage valids and data/flag registers.
  - Output reset values: out_valid=0, zero=0, ones=0, neg=0, zero_cnt=0.
  - in_ready reads 1 after reset, since out_valid=0.
  - Reset mid-operation drops all in-flight results; none appear after deassertion.
- Counter (feature enabled):
  - Increments when out_valid && out_ready && zero.
  - Saturates at 2^CNT_W-1 and does not wrap.
  - cnt_clr=1 forces 0 on the next edge and takes priority over a simultaneous increment.
- WIDTH=1: LEVELS=1, so a single register stage; zero=~data[0], ones=neg=data[0].

Optional Feature:
- Macro ZERO_FLAG_CNT_EN.
- Defined: zero_cnt behaves as described above.
- Undefined:
  - No counter register is built.
  - zero_cnt is tied to all zeros and cnt_clr is ignored.
  - All other behaviour is identical.

Test Plan:
1. WIDTH=32, FAN=4. Reset, then apply data=32'h0000_0000 with in_valid=1 for one cycle and out_ready=1 -> out_valid=1 exactly 3 cycles after the accept edge with zero=1, ones=0, neg=0.
2. Back-to-back inputs 0, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0001 with out_ready=1 -> four consecutive out_valid cycles with (zero,ones,neg) = (1,0,0), (0,1,1), (0,0,1), (0,0,0); in_ready held at 1.
3. Stall: with a result at the output, hold out_ready=0 for 5 cycles while in_valid=1 -> in_ready=0, outputs frozen, no input lost. Release out_ready -> the remaining results arrive in order.
4. Counter: deliver 3 zero results and 2 nonzero results -> zero_cnt=3. Assert cnt_clr on the same cycle as a zero delivery -> zero_cnt=0. With CNT_W=2, deliver 5 zeros -> zero_cnt=3 (saturated).
5. Assert rst while 3 results are in flight -> out_valid=0 immediately (asynchronous), zero_cnt=0, and no stale result emerges in the following 5 cycles.
6. WIDTH=10, FAN=4 (LEVELS=2). data=10'h000 -> zero=1; data=10'h3FF -> ones=1 (padding check). Build without ZERO_FLAG_CNT_EN -> zero_cnt stays 0 throughout.

Source files
------------

// File: rtl/zero_flag_pipe.sv
// Pipelined zero / all-ones / negative flag detector built from a registered FAN-input OR/AND tree.
// Optional saturating zero-result counter is built only when ZERO_FLAG_CNT_EN is defined.
module zero_flag_pipe #(
    parameter int WIDTH = 32,
    parameter int FAN   = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             zero,
    output logic             ones,
    output logic             neg,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] zero_cnt
);

    function automatic int f_nodes(input int w, input int fan, input int lvl);
        int n;
        n = w;
        for (int i = 0; i < lvl; i++) n = (n + fan - 1) / fan;
        return n;
    endfunction

    function automatic int f_levels(input int w, input int fan);
        int n;
        int l;
        n = w;
        l = 0;
        while (n > 1) begin
            n = (n + fan - 1) / fan;
            l++;
        end
        return (l < 1) ? 1 : l;
    endfunction

    function automatic int f_off(input int w, input int fan, input int lvl);
        int s;
        s = 0;
        for (int i = 0; i < lvl; i++) s += f_nodes(w, fan, i);
        return s;
    endfunction

    localparam int LEVELS = f_levels(WIDTH, FAN);
    localparam int TOT    = f_off(WIDTH, FAN, LEVELS + 1);

    // All tree levels share one flat bus; level l occupies [f_off(l) +: f_nodes(l)].
    logic [TOT-1:0]    w_or_bus;
    logic [TOT-1:0]    w_and_bus;
    logic [LEVELS-1:0] r_vld;
    logic [LEVELS-1:0] r_msb;
    logic              w_adv;

    assign w_adv     = out_ready || !out_valid;
    assign in_ready  = w_adv;
    assign w_or_bus[WIDTH-1:0]  = data;
    assign w_and_bus[WIDTH-1:0] = data;

    for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
        localparam int NI   = f_nodes(WIDTH, FAN, l);
        localparam int NO   = f_nodes(WIDTH, FAN, l + 1);
        localparam int OI   = f_off(WIDTH, FAN, l);
        localparam int OO   = f_off(WIDTH, FAN, l + 1);
        localparam bit LAST = (l == LEVELS - 1);

        logic [NO*FAN-1:0] w_or_pad;
        logic [NO*FAN-1:0] w_and_pad;
        logic [NO-1:0]     w_or_red;
        logic [NO-1:0]     w_and_red;
        logic [NO-1:0]     r_or;
        logic [NO-1:0]     r_and;
        logic              w_vld_in;

        if (l == 0) begin : g_src_in
            assign w_vld_in = in_valid;
        end else begin : g_src_prev
            assign w_vld_in = r_vld[l-1];
        end

        always_comb begin
            w_or_pad  = '0;
            w_and_pad = '1;
            w_or_pad[NI-1:0]  = w_or_bus[OI +: NI];
            w_and_pad[NI-1:0] = w_and_bus[OI +: NI];
            for (int j = 0; j < NO; j++) begin
                w_or_red[j]  = |w_or_pad[j*FAN +: FAN];
                w_and_red[j] = &w_and_pad[j*FAN +: FAN];
            end
        end

        // Last-level OR resets to 1 so the zero flag reads 0 out of reset.
        // Bubbles never load, so flags hold while out_valid is low.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_or  <= {NO{LAST}};
                r_and <= '0;
            end else if (w_adv && w_vld_in) begin
                r_or  <= w_or_red;
                r_and <= w_and_red;
            end
        end

        assign w_or_bus[OO +: NO]  = r_or;
        assign w_and_bus[OO +: NO] = r_and;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld <= '0;
            r_msb <= '0;
        end else if (w_adv) begin
            r_vld[0] <= in_valid;
            if (in_valid) r_msb[0] <= data[WIDTH-1];
            for (int l = 1; l < LEVELS; l++) begin
                r_vld[l] <= r_vld[l-1];
                if (r_vld[l-1]) r_msb[l] <= r_msb[l-1];
            end
        end
    end

    assign out_valid = r_vld[LEVELS-1];
    assign neg       = r_msb[LEVELS-1];
    assign zero      = ~w_or_bus[TOT-1];
    assign ones      = w_and_bus[TOT-1];

`ifdef ZERO_FLAG_CNT_EN
    logic [CNT_W-1:0] r_cnt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (cnt_clr) begin
            r_cnt <= '0;
        end else if (out_valid && out_ready && zero) begin
            r_cnt <= sat_inc(r_cnt);
        end
    end

    assign zero_cnt = r_cnt;
`else
    logic w_unused_clr;

    assign w_unused_clr = cnt_clr;
    assign zero_cnt     = '0;
`endif

endmodule

// File: tb/tb_zero_flag_pipe.sv
// Directed bench for zero_flag_pipe: a 32-bit/FAN-4 instance and a 10-bit/FAN-4/CNT_W-2 instance.
// Counter expectations follow whether ZERO_FLAG_CNT_EN is defined for the build.
module tb_zero_flag_pipe;

`ifdef ZERO_FLAG_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        clk;
    logic        rst;

    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [31:0] a_data;
    logic        a_zero, a_ones, a_neg, a_cnt_clr;
    logic [15:0] a_zero_cnt;

    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [9:0]  b_data;
    logic        b_zero, b_ones, b_neg, b_cnt_clr;
    logic [1:0]  b_zero_cnt;

    int checks = 0;
    int errors = 0;

    zero_flag_pipe #(.WIDTH(32), .FAN(4), .CNT_W(16)) u_a (
        .clk(clk), .rst(rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .data(a_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .zero(a_zero), .ones(a_ones), .neg(a_neg),
        .cnt_clr(a_cnt_clr), .zero_cnt(a_zero_cnt)
    );

    zero_flag_pipe #(.WIDTH(10), .FAN(4), .CNT_W(2)) u_b (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .data(b_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .zero(b_zero), .ones(b_ones), .neg(b_neg),
        .cnt_clr(b_cnt_clr), .zero_cnt(b_zero_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        a_in_valid = 0; a_data = '0; a_out_ready = 1; a_cnt_clr = 0;
        b_in_valid = 0; b_data = '0; b_out_ready = 1; b_cnt_clr = 0;
        repeat (2) tick();
        checks++;
        if ({a_out_valid, a_zero, a_ones, a_neg} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: got %b want 0000", {a_out_valid, a_zero, a_ones, a_neg});
        end
        checks++;
        if (a_zero_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_cnt: got %0d want 0", a_zero_cnt);
        end
        checks++;
        if (a_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b want 1", a_in_ready);
        end
        checks++;
        if ({b_out_valid, b_zero, b_ones, b_neg} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_b_flags: got %b want 0000", {b_out_valid, b_zero, b_ones, b_neg});
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_latency();
        int lat;
        a_data = 32'h0000_0000;
        a_in_valid = 1;
        tick();
        lat = 1;
        a_in_valid = 0;
        while (!a_out_valid && lat < 8) begin
            tick();
            lat++;
        end
        checks++;
        if (lat !== 3) begin
            errors++;
            $display("FAIL latency: got %0d edges want 3", lat);
        end
        checks++;
        if ({a_zero, a_ones, a_neg} !== 3'b100) begin
            errors++;
            $display("FAIL latency_flags: got %b want 100", {a_zero, a_ones, a_neg});
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [31:0] vec [4];
        logic [2:0]  exp [4];
        int k, first, last;
        vec = '{32'h0000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0001};
        exp = '{3'b100, 3'b011, 3'b001, 3'b000};
        k = 0; first = -1; last = -1;
        for (int cyc = 0; cyc < 10; cyc++) begin
            a_in_valid = (cyc < 4);
            a_data = (cyc < 4) ? vec[cyc] : 32'h0;
            #1;
            if (cyc < 4) begin
                checks++;
                if (a_in_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_in_ready: cyc %0d got %b want 1", cyc, a_in_ready);
                end
            end
            tick();
            if (a_out_valid && k < 4) begin
                checks++;
                if ({a_zero, a_ones, a_neg} !== exp[k]) begin
                    errors++;
                    $display("FAIL b2b_flags[%0d]: got %b want %b", k, {a_zero, a_ones, a_neg}, exp[k]);
                end
                if (first < 0) first = cyc;
                last = cyc;
                k++;
            end
        end
        checks++;
        if (k !== 4 || (last - first) !== 3) begin
            errors++;
            $display("FAIL b2b_count: got %0d results over %0d cycles want 4 over 3", k, last - first);
        end
    endtask

    task automatic test_stall();
        logic [31:0] vec [6];
        logic [2:0]  exp [6];
        logic [2:0]  held;
        int sent, recv, stall_cnt;
        logic acc, hs;
        vec = '{32'h0000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0001, 32'h0000_0000, 32'h7FFF_FFFF};
        exp = '{3'b100, 3'b011, 3'b001, 3'b000, 3'b100, 3'b000};
        sent = 0; recv = 0; stall_cnt = 0; held = '0;
        for (int cyc = 0; cyc < 40 && recv < 6; cyc++) begin
            a_in_valid = (sent < 6);
            a_data = (sent < 6) ? vec[sent] : 32'h0;
            a_out_ready = !(a_out_valid && stall_cnt < 5);
            #1;
            if (!a_out_ready) begin
                checks++;
                if (a_in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_in_ready: got %b want 0", a_in_ready);
                end
                if (stall_cnt == 0) begin
                    held = {a_zero, a_ones, a_neg};
                end else begin
                    checks++;
                    if ({a_zero, a_ones, a_neg} !== held || a_out_valid !== 1'b1) begin
                        errors++;
                        $display("FAIL stall_hold: got %b/%b want %b/1", {a_zero, a_ones, a_neg}, a_out_valid, held);
                    end
                end
                stall_cnt++;
            end
            acc = a_in_valid && a_in_ready;
            hs = a_out_valid && a_out_ready;
            if (hs) begin
                checks++;
                if ({a_zero, a_ones, a_neg} !== exp[recv]) begin
                    errors++;
                    $display("FAIL stall_order[%0d]: got %b want %b", recv, {a_zero, a_ones, a_neg}, exp[recv]);
                end
                recv++;
            end
            tick();
            if (acc) sent++;
        end
        a_in_valid = 0;
        a_out_ready = 1;
        checks++;
        if (recv !== 6 || sent !== 6 || stall_cnt !== 5) begin
            errors++;
            $display("FAIL stall_totals: got sent %0d recv %0d stall %0d want 6 6 5", sent, recv, stall_cnt);
        end
    endtask

    task automatic test_counter();
        logic [31:0] vec [5];
        int w;
        vec = '{32'h0, 32'h0, 32'h5, 32'h0, 32'hFFFF_FFFF};
        reset_pulse();
        a_out_ready = 1;
        for (int i = 0; i < 5; i++) begin
            a_in_valid = 1;
            a_data = vec[i];
            tick();
        end
        a_in_valid = 0;
        repeat (6) tick();
        checks++;
        if (a_zero_cnt !== (CNT_EN ? 16'd3 : 16'd0)) begin
            errors++;
            $display("FAIL cnt_three: got %0d want %0d", a_zero_cnt, CNT_EN ? 3 : 0);
        end
        a_in_valid = 1;
        a_data = 32'h0;
        tick();
        a_in_valid = 0;
        w = 0;
        while (!a_out_valid && w < 8) begin
            tick();
            w++;
        end
        checks++;
        if (a_out_valid !== 1'b1 || a_zero !== 1'b1) begin
            errors++;
            $display("FAIL cnt_clr_setup: got valid %b zero %b want 1 1", a_out_valid, a_zero);
        end
        a_cnt_clr = 1;
        tick();
        a_cnt_clr = 0;
        checks++;
        if (a_zero_cnt !== 16'd0) begin
            errors++;
            $display("FAIL cnt_clr_priority: got %0d want 0", a_zero_cnt);
        end
        repeat (3) tick();
        checks++;
        if (a_zero_cnt !== 16'd0) begin
            errors++;
            $display("FAIL cnt_clr_hold: got %0d want 0", a_zero_cnt);
        end
        b_out_ready = 1;
        for (int i = 0; i < 5; i++) begin
            b_in_valid = 1;
            b_data = 10'h000;
            tick();
        end
        b_in_valid = 0;
        repeat (5) tick();
        checks++;
        if (b_zero_cnt !== (CNT_EN ? 2'd3 : 2'd0)) begin
            errors++;
            $display("FAIL cnt_saturate: got %0d want %0d", b_zero_cnt, CNT_EN ? 3 : 0);
        end
    endtask

    task automatic test_reset_in_flight();
        reset_pulse();
        a_out_ready = 1;
        for (int i = 0; i < 4; i++) begin
            a_in_valid = 1;
            a_data = 32'h0;
            tick();
        end
        a_in_valid = 0;
        checks++;
        if (a_out_valid !== 1'b1 || a_zero_cnt !== (CNT_EN ? 16'd1 : 16'd0)) begin
            errors++;
            $display("FAIL flight_setup: got valid %b cnt %0d want 1 %0d", a_out_valid, a_zero_cnt, CNT_EN ? 1 : 0);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (a_out_valid !== 1'b0 || a_zero_cnt !== 16'd0) begin
            errors++;
            $display("FAIL async_reset: got valid %b cnt %0d want 0 0", a_out_valid, a_zero_cnt);
        end
        #2;
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (a_out_valid !== 1'b0) begin
                errors++;
                $display("FAIL stale_result: cycle %0d got valid %b want 0", i, a_out_valid);
            end
        end
    endtask

    task automatic test_width10();
        logic [9:0] vec [4];
        logic [2:0] exp [4];
        int k, first;
        vec = '{10'h000, 10'h3FF, 10'h1FF, 10'h200};
        exp = '{3'b100, 3'b011, 3'b000, 3'b001};
        k = 0; first = -1;
        b_out_ready = 1;
        for (int cyc = 0; cyc < 8; cyc++) begin
            b_in_valid = (cyc < 4);
            b_data = (cyc < 4) ? vec[cyc] : 10'h0;
            tick();
            if (b_out_valid && k < 4) begin
                checks++;
                if ({b_zero, b_ones, b_neg} !== exp[k]) begin
                    errors++;
                    $display("FAIL w10_flags[%0d]: got %b want %b", k, {b_zero, b_ones, b_neg}, exp[k]);
                end
                if (first < 0) first = cyc;
                k++;
            end
        end
        b_in_valid = 0;
        checks++;
        if (k !== 4 || first !== 1) begin
            errors++;
            $display("FAIL w10_latency: got %0d results first at %0d want 4 at 1", k, first);
        end
        checks++;
        if (b_zero_cnt !== (CNT_EN ? 2'd1 : 2'd0)) begin
            errors++;
            $display("FAIL w10_cnt: got %0d want %0d", b_zero_cnt, CNT_EN ? 1 : 0);
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_back_to_back();
        test_stall();
        test_width10();
        test_counter();
        test_reset_in_flight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
